mem_port_arbiter: RTL and testbench

- Shares the single synchronous-read data/instruction memory port between the instruction-fetch stage (IF) and the load/store stage (LS) of the multi-cycle core.
- Allows one outstanding access. LS has fixed priority, with a starvation guard that protects fetch.
- Sits between the core's fetch/execute sequencing and the BRAM; it replaces direct `pc`/`addr` drive of memory.

---
 rtl/core_pkg.sv | 31 +++
 rtl/mem_port_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: memory-port arbiter state/owner encodings and the
// requester-side timing parameters the core uses to size its pipeline waits.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int ARB_ADDR_W     = 16;
    localparam int ARB_MEM_LAT    = 1;
    localparam int ARB_STARVE_MAX = 4;

    // Cycles from a gnt pulse to the matching rvalid pulse.
    function automatic int arb_gnt_to_rvalid(input int mem_lat);
        return mem_lat + 1;
    endfunction

    // Minimum spacing between two consecutive grants.
    function automatic int arb_issue_period(input int mem_lat);
        return mem_lat + 2;
    endfunction

endpackage

// File: rtl/mem_port_arb_pick.sv
// Combinational winner picker: LS has priority unless fetch has been passed
// over STARVE_MAX times in a row; also produces the next starvation count.
module mem_port_arb_pick
    import core_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             ls_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             pick_valid,
    output logic             pick_ls,
    output logic [CNT_W-1:0] starve_next
);

    logic if_starved;

    assign if_starved = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        pick_valid  = if_req | ls_req;
        pick_ls     = 1'b0;
        starve_next = '0;
        if (ls_req && !if_starved) begin
            pick_ls = 1'b1;
            // LS can only win over a waiting fetch below the limit, so no overflow here
            if (if_req) begin
                starve_next = starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one synchronous-read memory port between
// fetch and load/store. Optional stall counters: MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_wstrb,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_we,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output logic [31:0]       if_stall_cnt,
    output logic [31:0]       ls_stall_cnt,
`endif
    input  logic [31:0]       mem_dout
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = 3;

    arb_state_t        state_reg, state_next;
    owner_t            owner_reg;
    logic [CNT_W-1:0]  starve_reg;
    logic [LAT_W-1:0]  lat_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic              we_reg;
    logic [31:0]       if_rdata_reg;
    logic [31:0]       ls_rdata_reg;

    logic              arb_point;
    logic              lat_done;
    logic              pick_valid;
    logic              pick_ls;
    logic [CNT_W-1:0]  starve_next;
    logic              unused_addr_bits;

    assign arb_point = (state_reg == S_IDLE) || (state_reg == S_RESP);
    assign lat_done  = (lat_reg == '0);
    assign unused_addr_bits = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0],
                                ls_addr[31:ADDR_W+2], ls_addr[1:0]};

    mem_port_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .starve_cnt  (starve_reg),
        .pick_valid  (pick_valid),
        .pick_ls     (pick_ls),
        .starve_next (starve_next)
    );

    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        ls_rvalid  = 1'b0;
        mem_we     = 4'b0000;
        unique case (state_reg)
            S_IDLE: begin
                if (pick_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                state_next = S_WAIT;
                if_gnt     = (owner_reg == OWN_IF);
                ls_gnt     = (owner_reg == OWN_LS);
                mem_we     = we_reg ? wstrb_reg : 4'b0000;
            end
            S_WAIT: begin
                if (lat_done) state_next = S_RESP;
            end
            S_RESP: begin
                state_next = pick_valid ? S_ISSUE : S_IDLE;
                if_rvalid  = (owner_reg == OWN_IF);
                ls_rvalid  = (owner_reg == OWN_LS);
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mem_addr = addr_reg;
    assign mem_din  = wdata_reg;
    assign if_rdata = if_rdata_reg;
    assign ls_rdata = ls_rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            owner_reg    <= OWN_IF;
            starve_reg   <= '0;
            lat_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            we_reg       <= 1'b0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (arb_point) begin
                starve_reg <= starve_next;
                if (pick_valid) begin
                    owner_reg <= pick_ls ? OWN_LS : OWN_IF;
                    addr_reg  <= pick_ls ? ls_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
                    wdata_reg <= pick_ls ? ls_wdata : 32'h0;
                    wstrb_reg <= pick_ls ? ls_wstrb : 4'b0000;
                    we_reg    <= pick_ls & ls_we;
                end
            end
            // Counter is loaded in ISSUE so that WAIT spans exactly MEM_LAT cycles
            if (state_reg == S_ISSUE) begin
                lat_reg <= LAT_W'(MEM_LAT - 1);
            end else if ((state_reg == S_WAIT) && !lat_done) begin
                lat_reg <= lat_reg - LAT_W'(1);
            end
            if ((state_reg == S_WAIT) && lat_done) begin
                if (owner_reg == OWN_LS) ls_rdata_reg <= we_reg ? 32'h0 : mem_dout;
                else                     if_rdata_reg <= mem_dout;
            end
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_cnt <= '0;
            ls_stall_cnt <= '0;
        end else begin
            if (if_req && !if_gnt) if_stall_cnt <= if_stall_cnt + 32'd1;
            if (ls_req && !ls_gnt) ls_stall_cnt <= ls_stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_if_hold: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_gnt) |=> if_req);
    a_ls_hold: assert property (@(posedge clk) disable iff (rst)
        (ls_req && !ls_gnt) |=> ls_req);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_PERF_EN
    localparam int MEM_LAT = 3;
`else
    localparam int MEM_LAT = 1;
`endif
    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_wstrb = 4'h0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout = 32'h0;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] if_stall_cnt, ls_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
`ifdef MEM_PORT_ARBITER_PERF_EN
        .if_stall_cnt(if_stall_cnt), .ls_stall_cnt(ls_stall_cnt),
`endif
        .mem_dout(mem_dout)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_txn_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_left = 3;

    logic [31:0] ref_mem [0:255];

    // Transaction-level model of the single outstanding access
    int          next_free = 0;
    int          starve    = 0;
    int          issue_cyc = -100;
    int          resp_cyc  = -100;
    int          zero_cyc  = -100;
    bit          own_ls    = 1'b0;
    bit          m_we      = 1'b0;
    logic [3:0]  m_wstrb   = 4'h0;
    logic [15:0] m_addr    = 16'h0;
    logic [31:0] m_wdata   = 32'h0;
    logic [31:0] m_rword   = 32'h0;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_ls_rdata = 32'h0;
    logic [31:0] exp_if_stall = 32'h0;
    logic [31:0] exp_ls_stall = 32'h0;

    // Requester state
    logic [31:0] if_q [$];
    ls_txn_t     ls_q [$];
    bit          if_pend = 1'b0;
    bit          ls_pend = 1'b0;
    bit          rand_mode = 1'b0;
    int          launch_if_cyc = -1000;
    int          launch_ls_cyc = -1000;

    // Observations of the DUT for the hand-computed checks
    int          obs_if_gnt_cyc, obs_ls_gnt_cyc, obs_if_rv_cyc, obs_ls_rv_cyc;
    logic [31:0] obs_if_gnt_addr, obs_ls_gnt_addr, obs_ls_gnt_din;
    logic [3:0]  obs_if_gnt_we, obs_ls_gnt_we;
    logic [31:0] obs_if_rv_data, obs_ls_rv_data;
    int          obs_we_cycles, obs_rv_count;
    logic [31:0] obs_post_reset;
    int          obs_seq [$];
    int          obs_ls_gnt_q [$];

    logic [3:0] strb_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic clear_obs();
        obs_if_gnt_cyc = -1000; obs_ls_gnt_cyc = -1000;
        obs_if_rv_cyc  = -1000; obs_ls_rv_cyc  = -1000;
        obs_if_gnt_addr = 32'hFFFF_FFFF; obs_ls_gnt_addr = 32'hFFFF_FFFF;
        obs_ls_gnt_din  = 32'hFFFF_FFFF;
        obs_if_gnt_we = 4'hA; obs_ls_gnt_we = 4'hA;
        obs_if_rv_data = 32'hFFFF_FFFF; obs_ls_rv_data = 32'hFFFF_FFFF;
        obs_we_cycles = 0; obs_rv_count = 0;
        obs_seq.delete(); obs_ls_gnt_q.delete();
    endtask

    task automatic compare_outputs();
        bit e_iss, e_resp;
        e_iss  = (cyc == issue_cyc);
        e_resp = (cyc == resp_cyc);
        if (e_resp) begin
            if (own_ls) exp_ls_rdata = m_we ? 32'h0 : m_rword;
            else        exp_if_rdata = m_rword;
        end
        chk("if_gnt",    32'(if_gnt),    32'(e_iss && !own_ls));
        chk("ls_gnt",    32'(ls_gnt),    32'(e_iss && own_ls));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_resp && !own_ls));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(e_resp && own_ls));
        chk("gnt_exclusive", 32'(if_gnt & ls_gnt), 32'h0);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("ls_rdata", ls_rdata, exp_ls_rdata);
        chk("mem_we", 32'(mem_we), (e_iss && m_we) ? 32'(m_wstrb) : 32'h0);
        if (cyc >= issue_cyc && cyc <= issue_cyc + MEM_LAT) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (e_iss && m_we) chk("mem_din", mem_din, m_wdata);
        if (cyc == zero_cyc) begin
            chk("reset_mem_addr", 32'(mem_addr), 32'h0);
            chk("reset_mem_din", mem_din, 32'h0);
            obs_post_reset = {31'h0, if_gnt | ls_gnt | if_rvalid | ls_rvalid | (|mem_we)}
                             | 32'(mem_addr) | mem_din | if_rdata | ls_rdata;
        end
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("if_stall_cnt", if_stall_cnt, exp_if_stall);
        chk("ls_stall_cnt", ls_stall_cnt, exp_ls_stall);
`endif
        if (if_gnt) begin
            obs_if_gnt_cyc = cyc; obs_if_gnt_addr = 32'(mem_addr); obs_if_gnt_we = mem_we;
            obs_seq.push_back(0);
        end
        if (ls_gnt) begin
            obs_ls_gnt_cyc = cyc; obs_ls_gnt_addr = 32'(mem_addr); obs_ls_gnt_we = mem_we;
            obs_ls_gnt_din = mem_din;
            obs_seq.push_back(1); obs_ls_gnt_q.push_back(cyc);
        end
        if (if_rvalid) begin obs_if_rv_cyc = cyc; obs_if_rv_data = if_rdata; obs_rv_count++; end
        if (ls_rvalid) begin obs_ls_rv_cyc = cyc; obs_ls_rv_data = ls_rdata; obs_rv_count++; end
        if (mem_we != 4'h0) obs_we_cycles++;
    endtask

    task automatic requesters();
        bit g_if, g_ls;
        ls_txn_t t;
        g_if = (cyc == issue_cyc) && !own_ls;
        g_ls = (cyc == issue_cyc) && own_ls;
        // Inputs stay put through the grant cycle; a new request may start afterwards
        if (g_if) if_pend = 1'b0;
        else if (!if_pend) begin
            if (if_q.size() > 0) begin
                if_addr = if_q.pop_front(); if_req = 1'b1; if_pend = 1'b1; launch_if_cyc = cyc;
            end else if (rand_mode && $urandom_range(0, 99) < 40) begin
                if_addr = rand_addr(); if_req = 1'b1; if_pend = 1'b1;
            end else if_req = 1'b0;
        end
        if (g_ls) ls_pend = 1'b0;
        else if (!ls_pend) begin
            if (ls_q.size() > 0) begin
                t = ls_q.pop_front(); launch_ls_cyc = cyc;
                ls_we = t.we; ls_wstrb = t.wstrb; ls_addr = t.addr; ls_wdata = t.wdata;
                ls_req = 1'b1; ls_pend = 1'b1;
            end else if (rand_mode && $urandom_range(0, 99) < 40) begin
                ls_we = 1'($urandom_range(0, 1)); ls_wstrb = strb_tab[$urandom_range(0, 6)];
                ls_addr = rand_addr(); ls_wdata = $urandom;
                ls_req = 1'b1; ls_pend = 1'b1;
            end else ls_req = 1'b0;
        end
    endtask

    task automatic model_step();
        bit g_if, g_ls, win_ls;
        logic [7:0] idx;
        g_if = (cyc == issue_cyc) && !own_ls;
        g_ls = (cyc == issue_cyc) && own_ls;
        if (rst) begin
            issue_cyc = -100; resp_cyc = -100; zero_cyc = cyc + 1;
            next_free = cyc + 1; starve = 0;
            exp_if_rdata = 32'h0; exp_ls_rdata = 32'h0;
            exp_if_stall = 32'h0; exp_ls_stall = 32'h0;
        end else begin
            if (if_req && !g_if) exp_if_stall = exp_if_stall + 32'd1;
            if (ls_req && !g_ls) exp_ls_stall = exp_ls_stall + 32'd1;
            if (cyc >= next_free) begin
                if (!if_req && !ls_req) begin
                    starve = 0; next_free = cyc + 1;
                end else begin
                    win_ls = ls_req && !(if_req && starve == STARVE_MAX);
                    starve = (win_ls && if_req) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                    own_ls  = win_ls;
                    m_addr  = win_ls ? ls_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
                    m_we    = win_ls && ls_we;
                    m_wstrb = ls_wstrb;
                    m_wdata = ls_wdata;
                    idx     = m_addr[7:0];
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) ref_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
                    end
                    m_rword   = ref_mem[idx];
                    issue_cyc = cyc + 1;
                    resp_cyc  = cyc + 2 + MEM_LAT;
                    next_free = resp_cyc;
                end
            end
        end
        // Memory data is only meaningful in the sampling cycle; elsewhere it is noise
        mem_dout = (!rst && cyc == issue_cyc + MEM_LAT && !m_we) ? m_rword : $urandom;
        cyc++;
    endtask

    task automatic advance();
        @(negedge clk);
        compare_outputs();
        requesters();
        rst = (rst_left > 0);
        if (rst_left > 0) rst_left--;
        model_step();
    endtask

    task automatic push_ls(input bit we, input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d);
        ls_txn_t t;
        t.we = we; t.wstrb = strb; t.addr = a; t.wdata = d;
        ls_q.push_back(t);
    endtask

    int exp_seq [7] = '{1, 1, 1, 1, 0, 1, 1};
    logic [31:0] stall_s0;

    initial begin
        for (int i = 0; i < 256; i++)
            ref_mem[i] = {8'hA5, 8'(i), ~8'(i), 8'h3C};
        clear_obs();

        // Reset state
        repeat (5) advance();
        chk("reset_outputs_zero", {27'h0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, |mem_we}, 32'h0);

        // Single fetch
        clear_obs();
        if_q.push_back(32'h10);
        repeat (MEM_LAT + 6) advance();
        chk("fetch_gnt_delay", 32'(obs_if_gnt_cyc - launch_if_cyc), 32'd1);
        chk("fetch_mem_addr", obs_if_gnt_addr, 32'h4);
        chk("fetch_mem_we", 32'(obs_if_gnt_we), 32'h0);
        chk("fetch_rvalid_delay", 32'(obs_if_rv_cyc - obs_if_gnt_cyc), 32'(MEM_LAT + 1));
        chk("fetch_rdata", obs_if_rv_data, 32'hA504FB3C);

        // Word store
        clear_obs();
        push_ls(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
        repeat (MEM_LAT + 6) advance();
        chk("store_mem_we", 32'(obs_ls_gnt_we), 32'hF);
        chk("store_mem_addr", obs_ls_gnt_addr, 32'h8);
        chk("store_mem_din", obs_ls_gnt_din, 32'hDEADBEEF);
        chk("store_we_cycles", 32'(obs_we_cycles), 32'd1);
        chk("store_rvalid_delay", 32'(obs_ls_rv_cyc - obs_ls_gnt_cyc), 32'(MEM_LAT + 1));
        chk("store_rdata", obs_ls_rv_data, 32'h0);

        // Collision
        clear_obs();
        if_q.push_back(32'h40);
        push_ls(1'b0, 4'h0, 32'h44, 32'h0);
        repeat (2 * (MEM_LAT + 2) + 4) advance();
        chk("collide_ls_gnt_delay", 32'(obs_ls_gnt_cyc - launch_ls_cyc), 32'd1);
        chk("collide_if_gnt_delay", 32'(obs_if_gnt_cyc - launch_if_cyc), 32'(MEM_LAT + 3));
        chk("collide_ls_rdata", obs_ls_rv_data, 32'hA511EE3C);
        chk("collide_if_rdata", obs_if_rv_data, 32'hA510EF3C);

        // Starvation guard
        clear_obs();
        for (int k = 0; k < 6; k++) push_ls(1'b0, 4'h0, 32'h80 + 32'(4 * k), 32'h0);
        if_q.push_back(32'h100);
        repeat (8 * (MEM_LAT + 2) + 4) advance();
        chk("starve_grant_count", 32'(obs_seq.size()), 32'd7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("starve_grant_%0d", k), (k < obs_seq.size()) ? 32'(obs_seq[k]) : 32'hEE, 32'(exp_seq[k]));

        // Reset during WAIT
        clear_obs();
        if_q.push_back(32'h50);
        advance();
        advance();
        rst_left = 1;
        obs_post_reset = 32'hFFFF_FFFF;
        repeat (MEM_LAT + 5) advance();
        chk("reset_no_rvalid", 32'(obs_rv_count), 32'd0);
        chk("reset_all_zero", obs_post_reset, 32'h0);
        clear_obs();
        if_q.push_back(32'h60);
        repeat (MEM_LAT + 6) advance();
        chk("after_reset_gnt_delay", 32'(obs_if_gnt_cyc - launch_if_cyc), 32'd1);
        chk("after_reset_rdata", obs_if_rv_data, 32'hA518E73C);

        // Back-to-back loads
        clear_obs();
`ifdef MEM_PORT_ARBITER_PERF_EN
        stall_s0 = ls_stall_cnt;
`else
        stall_s0 = 32'h0;
`endif
        push_ls(1'b0, 4'h0, 32'h30, 32'h0);
        push_ls(1'b0, 4'h0, 32'h34, 32'h0);
        repeat (2 * (MEM_LAT + 2) + 4) advance();
        chk("b2b_grant_count", 32'(obs_ls_gnt_q.size()), 32'd2);
        if (obs_ls_gnt_q.size() >= 2)
            chk("b2b_grant_spacing", 32'(obs_ls_gnt_q[1] - obs_ls_gnt_q[0]), 32'(MEM_LAT + 2));
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("b2b_ls_stall_delta", ls_stall_cnt - stall_s0, 32'(MEM_LAT + 2));
`endif

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (3000) advance();
        rand_mode = 1'b0;
        repeat (4 * (MEM_LAT + 2)) advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
